// File: rtl/aes_out_block_fifo.sv
// AES output block FIFO: buffers 128-bit plaintext blocks and
// presents the head block to the bus as 32-bit words, MSW first.
module aes_out_block_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic [127:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            word_rd,
  output logic [31:0]     word_data,
  output logic            word_valid,
  output logic [1:0]      word_idx,
  output logic            last_word,
  output logic [ADDR_W:0] level,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [ADDR_W:0] FULL_LVL =
    (ADDR_W+1)'(DEPTH);

  logic [127:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [127:0]      head;
  logic              push;
  logic              rd_ok;
  logic              pop;

  assign empty      = (level == '0);
  assign full       = (level == FULL_LVL);
  assign in_ready   = !full;
  assign word_valid = !empty;
  assign last_word  = word_valid && (word_idx == 2'd3);

  assign push  = in_valid && !full && !flush;
  assign rd_ok = word_rd && !empty && !flush;
  assign pop   = rd_ok && (word_idx == 2'd3);

  assign head = mem[rd_ptr];

  always_comb begin
    word_data = '0;
    if (!empty) begin
      unique case (word_idx)
        2'd0: word_data = head[127:96];
        2'd1: word_data = head[95:64];
        2'd2: word_data = head[63:32];
        2'd3: word_data = head[31:0];
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      word_idx  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      word_idx  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rd_ok) word_idx <= word_idx + 2'd1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (in_valid && full) overflow <= 1'b1;
      if (word_rd && empty) underflow <= 1'b1;
    end
  end

endmodule
